// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one shift-and-correct step per clock.
// Optional macro BCD2BIN_CHECK_EN rejects operands holding a digit above 9 with a one-cycle error completion.
module bcd2bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic                busy,
    output logic                done,
    output logic [BIN_W-1:0]    bin_out,
    output logic                err
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [BCD_W-1:0] bcd;
    logic [BIN_W-1:0] bin;

    logic [BCD_W-1:0] bcd_sh;
    logic [BIN_W-1:0] bin_sh;
    logic             bad;

    // Each digit that reached 8 or more after the halving step held an odd tens carry; pull it back by 3.
    function automatic logic [BCD_W-1:0] fix_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd8)
                r[4*i +: 4] = v[4*i +: 4] - 4'd3;
        end
        return r;
    endfunction

    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic any;
        any = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9)
                any = 1'b1;
        end
        return any;
    endfunction

    assign {bcd_sh, bin_sh} = {1'b0, bcd, bin[BIN_W-1:1]};

`ifdef BCD2BIN_CHECK_EN
    assign bad = has_bad_digit(bcd_in);
`else
    assign bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bcd     <= '0;
            bin     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (bad) begin
                            done    <= 1'b1;
                            err     <= 1'b1;
                            bin_out <= '0;
                        end else begin
                            bcd   <= bcd_in;
                            bin   <= '0;
                            cnt   <= '0;
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= CONV;
                        end
                    end
                end
                CONV: begin
                    bcd <= fix_digits(bcd_sh);
                    bin <= bin_sh;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bin_out <= bin_sh;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: default 4-digit/14-bit instance plus a 2-digit/7-bit instance.
// The invalid-digit section is active only when BCD2BIN_CHECK_EN is defined.
module tb_bcd2bin_seq;
    localparam int BIN_W  = 14;
    localparam int BIN_W2 = 7;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        start  = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        busy, done, err;
    logic [13:0] bin_out;

    logic        start2 = 1'b0;
    logic [7:0]  bcd2   = '0;
    logic        busy2, done2, err2;
    logic [6:0]  bin2;

    int n_assert = 0;
    int n_fail   = 0;

    bcd2bin_seq #(.DIGITS(4), .BIN_W(BIN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .bin_out(bin_out), .err(err)
    );

    bcd2bin_seq #(.DIGITS(2), .BIN_W(BIN_W2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bcd_in(bcd2),
        .busy(busy2), .done(done2), .bin_out(bin2), .err(err2)
    );

    always #5 clk = ~clk;

    // Reference: decimal value of the packed digits, reduced modulo 2^bin_w.
    function automatic int bcd_value(input logic [31:0] v, input int digits, input int bin_w);
        int acc;
        int scale;
        logic [31:0] t;
        acc = 0;
        scale = 1;
        t = v;
        for (int i = 0; i < digits; i++) begin
            acc += int'(t[3:0]) * scale;
            scale *= 10;
            t = t >> 4;
        end
        return acc % (1 << bin_w);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input bit noise, output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cnt++;
            if (noise) begin
                start  = 1'($urandom);
                bcd_in = 16'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic convert(input string tag, input logic [15:0] v, input int exp);
        int lat, bc;
        @(negedge clk);
        bcd_in = v;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, lat, bc);
        check({tag, "_latency"}, lat, BIN_W);
        check({tag, "_busy_cycles"}, bc, BIN_W);
        check({tag, "_bin"}, 32'(bin_out), exp);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_busy_at_done"}, 32'(busy), 0);
    endtask

    task automatic convert2(input string tag, input logic [7:0] v, input int exp);
        int lat;
        @(negedge clk);
        bcd2   = v;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 0;
        while (done2 !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, BIN_W2);
        check({tag, "_bin"}, 32'(bin2), exp);
        check({tag, "_err"}, 32'(err2), 0);
    endtask

    initial begin
        int lat, bc, seen;
        logic [15:0] v;
        logic [7:0]  v2;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_bin", 32'(bin_out), 0);
        check("reset_err", 32'(err), 0);
        rst_n = 1'b1;

        convert("zero", 16'h0000, 0);
        convert("max", 16'h9999, 9999);
        convert("b1234", 16'h1234, 16'h04D2);

        // Back-to-back: start held in the done cycle, noise on start/bcd_in while busy.
        convert("b2b_first", 16'h0042, 42);
        bcd_in = 16'h0100;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b1, lat, bc);
        check("b2b_latency", lat, BIN_W);
        check("b2b_busy_cycles", bc, BIN_W);
        check("b2b_bin", 32'(bin_out), 100);

        for (int n = 0; n < 8; n++) begin
            for (int d = 0; d < 4; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
            convert("rand", v, bcd_value(32'(v), 4, BIN_W));
        end

`ifdef BCD2BIN_CHECK_EN
        @(negedge clk);
        bcd_in = 16'h12A4;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("bad_done", 32'(done), 1);
        check("bad_err", 32'(err), 1);
        check("bad_bin", 32'(bin_out), 0);
        check("bad_busy", 32'(busy), 0);
        @(negedge clk);
        check("bad_done_drop", 32'(done), 0);
        check("bad_busy_after", 32'(busy), 0);
        check("bad_err_held", 32'(err), 1);
        bcd_in = 16'hF000;
        start  = 1'b1;
        @(negedge clk);
        check("bad_pair_first", 32'(done), 1);
        @(negedge clk);
        start = 1'b0;
        check("bad_pair_second", 32'(done), 1);
        @(negedge clk);
        check("bad_pair_end", 32'(done), 0);
`endif
        convert("seven", 16'h0007, 7);

        // Reset in the middle of a conversion.
        convert("pre_rst", 16'h0321, 321);
        @(negedge clk);
        bcd_in = 16'h5678;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_bin", 32'(bin_out), 0);
        check("midrst_err", 32'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("midrst_quiet", seen, 0);
        convert("after_rst", 16'h0010, 10);

        convert2("narrow_99", 8'h99, 99);
        for (int n = 0; n < 4; n++) begin
            for (int d = 0; d < 2; d++) v2[4*d +: 4] = 4'($urandom_range(0, 9));
            convert2("narrow_rand", v2, bcd_value(32'(v2), 2, BIN_W2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd2bin_seq.md
# bcd2bin_seq

Sequential BCD-to-binary converter, the inverse of the BCD adder's binary-to-BCD correction path. It takes a packed multi-digit BCD word and returns its unsigned binary value, one shift-and-correct iteration per clock (reverse double-dabble). It sits between BCD arithmetic results and binary consumers such as counters, comparators and address logic. Start/busy/done handshake; one conversion in flight at a time.

## Interface

- DIGITS, 4, number of BCD digits in `bcd_in`.
- BIN_W, 14, binary result width and iteration count.
  - Must be at least ceil(log2(10^DIGITS)) for exact results.
  - If smaller, the result is the value modulo 2^BIN_W.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a conversion; sampled only when `busy` is 0.
- bcd_in  input  4*DIGITS  packed BCD operand; digit 0 is in bits [3:0].
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse; result and `err` are valid.
- bin_out  output  BIN_W  binary result; held until the next completion.
- err  output  1  last request contained a digit > 9; held until the next completion.

## Operation

- Reset values: `busy`=0, `done`=0, `bin_out`=0, `err`=0, state IDLE, iteration counter 0, work register 0.
- States:
  - IDLE: `busy`=0.
  - CONV: `busy`=1.
- IDLE, `start`=1 at an edge:
  - `bcd_in` is captured into the BCD half of the work register.
  - The binary half (BIN_W bits) is cleared and the counter is cleared.
  - Next state is CONV.
  - `err` is cleared.
- CONV, each edge performs one iteration:
  - Shift the whole {bcd, bin} register right by 1; the BCD LSB enters the binary MSB.
  - Then, for every 4-bit BCD digit, if the digit ≥ 8, subtract 3 from that digit only, with no borrow into neighbouring digits.
  - Increment the counter.
- On the edge that completes iteration BIN_W:
  - `bin_out` is loaded with the binary half.
  - `done` is set to 1 for one cycle.
  - Next state is IDLE.
- `start` while `busy`=1 is ignored; `bcd_in` changes during CONV have no effect.
- `start` is accepted in the cycle where `done`=1, since `busy` is already 0 then, giving back-to-back conversions with no idle cycle.
- Invalid digits: handling depends on CHECK (see Configuration).
- `rst_n` low at any time, including mid-CONV:
  - Immediate return to reset values.
  - The partial result is discarded and no `done` is issued.

## Timing

- `start` sampled at edge k → `busy`=1 from edge k through edge k+BIN_W−1.
- `done`=1 and the new `bin_out` are visible for the cycle after edge k+BIN_W; `busy`=0 in that same cycle.
- Latency is BIN_W clocks (14 at defaults). Throughput is one conversion per BIN_W clocks.
- Invalid-digit rejection (CHECK enabled): `done`, `err`=1 and `bin_out`=0 are visible for the cycle after edge k (latency 1); `busy` never rises.
- `done` is never high for two consecutive cycles, except back-to-back invalid requests, each of which produces its own pulse.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration

- Macro BCD2BIN_CHECK_EN.
- Defined:
  - On an accepted `start`, every digit of `bcd_in` is compared against 9.
  - Any digit > 9: no conversion, the 1-cycle error completion described in Timing.
  - Valid input: `err`=0 at completion.
- Not defined:
  - No digit check; `err` is tied to 0.
  - Every request takes the full BIN_W-cycle conversion.
  - `bin_out` for invalid digits is implementation-defined but deterministic; the bench does not check it.

## Test plan

- Reset, then `bcd_in`=16'h0000 with `start` pulsed → `done` 14 clocks later, `bin_out`=0, `err`=0, `busy` high for exactly 14 cycles.
- `bcd_in`=16'h9999 → `bin_out`=14'd9999 (14'h270F); `bcd_in`=16'h1234 → `bin_out`=14'h04D2.
- `start` with 16'h0042 completes; `start` is held in the `done` cycle with 16'h0100 → second `done` exactly 14 clocks after the first, `bin_out`=100. Toggling `start`/`bcd_in` during `busy` changes nothing.
- BCD2BIN_CHECK_EN defined, `bcd_in`=16'h12A4 → next cycle `done`=1, `err`=1, `bin_out`=0, `busy` stays 0. A following 16'h0007 → `err`=0, `bin_out`=7.
- Start 16'h5678, assert `rst_n`=0 at iteration 6 → all outputs 0 immediately, no `done` after release. A new 16'h0010 request then → `bin_out`=10.
- DIGITS=2, BIN_W=7: `bcd_in`=8'h99 → `bin_out`=7'd99 after 7 clocks.
